// File: rtl/read_seq_pkg.sv
// Shared types for the read sequence checker: FSM state encoding, error counter width,
// and a saturating add helper for the mismatch counter.
package read_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_RUN,
        S_DONE
    } state_t;

    localparam int ERR_W = 8;

    // At most 8 channels can miss in one cycle, so a 4-bit increment is enough.
    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                  input logic [3:0]       b);
        logic [ERR_W:0] sum;
        sum = {1'b0, a} + {{(ERR_W-3){1'b0}}, b};
        return sum[ERR_W] ? '1 : sum[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/read_seq_lane.sv
// One read channel: derives its address from the shared step counter and
// checks the combinational read response against the expected pattern.
module read_seq_lane #(
    parameter int CH        = 0,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int DATA_MULT = 5
) (
    input  logic [ADDR_W-1:0] step,
    input  logic              run,
    input  logic              valid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rresp,
    output logic [ADDR_W-1:0] raddr,
    output logic              mismatch
);

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_data;

    // Truncation to ADDR_W gives the required modulo wrap.
    assign addr     = step + ADDR_W'(CH);
    assign raddr    = run ? addr : '0;
    assign exp_data = DATA_W'(32'(addr) * 32'(DATA_MULT));

    // With rvalid low the data is don't-care but a response flag is still an error.
    assign mismatch = run && (valid ? (!rresp || (rdata != exp_data)) : rresp);

endmodule

// File: rtl/read_seq_checker.sv
// Drives a fixed read sequence on NUM_CH channels after a warm-up period and
// accumulates mismatches between the returned data/response and the expected pattern.
module read_seq_checker
    import read_seq_pkg::*;
#(
    parameter int                       NUM_CH      = 2,
    parameter int                       ADDR_W      = 4,
    parameter int                       DATA_W      = 8,
    parameter int                       NUM_STEPS   = 8,
    parameter int                       WARMUP      = 4,
    parameter logic [(1<<ADDR_W)-1:0]   VALID_MASK  = 'b0011_0100,
    parameter int                       DATA_MULT   = 5,
    parameter int                       STOP_ON_ERR = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic [NUM_CH*ADDR_W-1:0] raddr,
    output logic [NUM_CH-1:0]        rvalid,
    input  logic [NUM_CH*DATA_W-1:0] rdata,
    input  logic [NUM_CH-1:0]        rresp,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_W-1:0]         err_count,
    output logic [ADDR_W-1:0]        first_err_step
);

    localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] step;
    logic [WC_W-1:0]   wcnt;
    logic [NUM_CH-1:0] mismatch;
    logic [3:0]        nerr;
    logic              run, any_err, last_step, warm_done;

    assign run       = (state == S_RUN);
    assign any_err   = |mismatch;
    assign last_step = (step == ADDR_W'(NUM_STEPS - 1));
    assign warm_done = (wcnt == WC_W'(WARMUP - 1));
    assign rvalid    = run ? {NUM_CH{VALID_MASK[step]}} : '0;

    assign busy = (state == S_WARMUP) || run;
    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        read_seq_lane #(
            .CH       (c),
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .DATA_MULT(DATA_MULT)
        ) u_lane (
            .step    (step),
            .run     (run),
            .valid   (rvalid[c]),
            .rdata   (rdata[c*DATA_W +: DATA_W]),
            .rresp   (rresp[c]),
            .raddr   (raddr[c*ADDR_W +: ADDR_W]),
            .mismatch(mismatch[c])
        );
    end

    always_comb begin
        nerr = '0;
        for (int i = 0; i < NUM_CH; i++) nerr = nerr + 4'(mismatch[i]);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_WARMUP;
            S_WARMUP: if (warm_done) state_nx = S_RUN;
            S_RUN:    if (last_step || ((STOP_ON_ERR != 0) && any_err)) state_nx = S_DONE;
            S_DONE:   if (start) state_nx = S_WARMUP;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            step           <= '0;
            wcnt           <= '0;
            err_count      <= '0;
            first_err_step <= '0;
        end else begin
            state <= state_nx;
            // Entering warm-up (from IDLE or DONE) starts a fresh run.
            if (state_nx == S_WARMUP && state != S_WARMUP) begin
                step           <= '0;
                wcnt           <= '0;
                err_count      <= '0;
                first_err_step <= '0;
            end else if (state == S_WARMUP) begin
                wcnt <= wcnt + 1'b1;
            end
            if (run) begin
                step <= step + 1'b1;
                if (any_err) begin
                    err_count <= sat_add(err_count, nerr);
                    if (err_count == '0) first_err_step <= step;
                end
            end
        end
    end

endmodule

// File: tb/tb_read_seq_checker.sv
// Bench for read_seq_checker: three configurations driven from one sequence, with a
// fault-injecting memory model and an expected-result model computed per run.
module tb_read_seq_checker;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   sel   = 0;

    always #5 clock = ~clock;

    // Fault plan indexed [step][channel]: 0 none, 1 corrupt data, 2 invert response.
    logic [1:0] fk [16][4];
    logic [7:0] fd [16][4];

    int n_cmp = 0;
    int n_bad = 0;

    int          cfg_nch  [3] = '{2, 2, 4};
    int          cfg_nst  [3] = '{8, 8, 16};
    int          cfg_stop [3] = '{0, 1, 0};
    logic [15:0] cfg_mask [3] = '{16'h0034, 16'h0034, 16'hE6B4};

    logic        start_a, start_b, start_c;
    logic [7:0]  raddr_a, raddr_b;
    logic [15:0] raddr_c;
    logic [1:0]  rvalid_a, rvalid_b, rresp_a, rresp_b;
    logic [3:0]  rvalid_c, rresp_c;
    logic [15:0] rdata_a, rdata_b;
    logic [31:0] rdata_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic [7:0]  err_a, err_b, err_c;
    logic [3:0]  fes_a, fes_b, fes_c;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    read_seq_checker u_a (
        .clock(clock), .reset(reset), .start(start_a), .raddr(raddr_a), .rvalid(rvalid_a),
        .rdata(rdata_a), .rresp(rresp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_step(fes_a));

    read_seq_checker #(.STOP_ON_ERR(1)) u_b (
        .clock(clock), .reset(reset), .start(start_b), .raddr(raddr_b), .rvalid(rvalid_b),
        .rdata(rdata_b), .rresp(rresp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_step(fes_b));

    read_seq_checker #(.NUM_CH(4), .NUM_STEPS(16), .VALID_MASK(16'hE6B4)) u_c (
        .clock(clock), .reset(reset), .start(start_c), .raddr(raddr_c), .rvalid(rvalid_c),
        .rdata(rdata_c), .rresp(rresp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_err_step(fes_c));

    // Memory model: rdata = raddr*5, rresp = rvalid, then the fault plan for the current step.
    always_comb begin
        rdata_a = '0; rresp_a = '0;
        for (int c = 0; c < 2; c++) begin
            rdata_a[c*8 +: 8] = 8'(raddr_a[c*4 +: 4] * 5) +
                ((fk[raddr_a[3:0]][c] == 2'd1) ? fd[raddr_a[3:0]][c] : 8'd0);
            rresp_a[c] = rvalid_a[c] ^ (fk[raddr_a[3:0]][c] == 2'd2);
        end
    end

    always_comb begin
        rdata_b = '0; rresp_b = '0;
        for (int c = 0; c < 2; c++) begin
            rdata_b[c*8 +: 8] = 8'(raddr_b[c*4 +: 4] * 5) +
                ((fk[raddr_b[3:0]][c] == 2'd1) ? fd[raddr_b[3:0]][c] : 8'd0);
            rresp_b[c] = rvalid_b[c] ^ (fk[raddr_b[3:0]][c] == 2'd2);
        end
    end

    always_comb begin
        rdata_c = '0; rresp_c = '0;
        for (int c = 0; c < 4; c++) begin
            rdata_c[c*8 +: 8] = 8'(raddr_c[c*4 +: 4] * 5) +
                ((fk[raddr_c[3:0]][c] == 2'd1) ? fd[raddr_c[3:0]][c] : 8'd0);
            rresp_c[c] = rvalid_c[c] ^ (fk[raddr_c[3:0]][c] == 2'd2);
        end
    end

    logic        busy_m, done_m, pass_m;
    logic [7:0]  err_m;
    logic [3:0]  fes_m, rvalid_m;
    logic [15:0] raddr_m;

    always_comb begin
        busy_m = busy_a; done_m = done_a; pass_m = pass_a; err_m = err_a; fes_m = fes_a;
        raddr_m = {8'h0, raddr_a}; rvalid_m = {2'b0, rvalid_a};
        if (sel == 1) begin
            busy_m = busy_b; done_m = done_b; pass_m = pass_b; err_m = err_b; fes_m = fes_b;
            raddr_m = {8'h0, raddr_b}; rvalid_m = {2'b0, rvalid_b};
        end else if (sel == 2) begin
            busy_m = busy_c; done_m = done_c; pass_m = pass_c; err_m = err_c; fes_m = fes_c;
            raddr_m = raddr_c; rvalid_m = rvalid_c;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int s = 0; s < 16; s++)
            for (int c = 0; c < 4; c++) begin
                fk[s][c] = 2'd0;
                fd[s][c] = 8'd1;
            end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},  32'(busy_m),  0);
        chk({tag, ".done"},  32'(done_m),  0);
        chk({tag, ".pass"},  32'(pass_m),  0);
        chk({tag, ".err"},   32'(err_m),   0);
        chk({tag, ".fes"},   32'(fes_m),   0);
        chk({tag, ".raddr"}, 32'(raddr_m), 0);
        chk({tag, ".rvalid"},32'(rvalid_m),0);
    endtask

    // Runs one sequence on config `which`; poke >= 0 pulses start at that busy cycle.
    task automatic run_cfg(input int which, input int poke, input string tag);
        int  nch, nst, exp_err, first, steps_run, k, cnt, st;
        bit  got_done;
        nch = cfg_nch[which];
        nst = cfg_nst[which];
        exp_err = 0; first = -1; steps_run = 0;
        for (int s = 0; s < nst; s++) begin
            cnt = 0;
            steps_run++;
            for (int c = 0; c < nch; c++) begin
                if (fk[s][c] == 2'd1 && cfg_mask[which][s]) cnt++;
                if (fk[s][c] == 2'd2) cnt++;
            end
            if (cnt > 0 && first < 0) first = s;
            exp_err += cnt;
            if (cfg_stop[which] != 0 && cnt > 0) break;
        end
        if (exp_err > 255) exp_err = 255;

        sel = which;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        k = 0; got_done = 0;
        for (int t = 0; t < 120; t++) begin
            if (done_m) begin got_done = 1; break; end
            chk({tag, ".busy"}, 32'(busy_m), 1);
            if (k >= 4) begin
                st = k - 4;
                for (int c = 0; c < nch; c++) begin
                    chk({tag, ".raddr"},  32'(raddr_m[c*4 +: 4]), 32'((st + c) % 16));
                    chk({tag, ".rvalid"}, 32'(rvalid_m[c]), 32'(cfg_mask[which][st % 16]));
                end
            end else begin
                chk({tag, ".rvalid_warm"}, 32'(rvalid_m), 0);
            end
            start = (k == poke);
            @(posedge clock); #1;
            k++;
        end
        start = 1'b0;
        chk({tag, ".done_seen"},   32'(got_done), 1);
        chk({tag, ".busy_cycles"}, 32'(k), 32'(4 + steps_run));
        chk({tag, ".busy_end"},    32'(busy_m), 0);
        chk({tag, ".err_count"},   32'(err_m), 32'(exp_err));
        chk({tag, ".first_err"},   32'(fes_m), 32'((first < 0) ? 0 : first));
        chk({tag, ".pass"},        32'(pass_m), 32'(exp_err == 0));
    endtask

    initial begin
        clear_faults();
        // Start held during reset must be ignored.
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        for (int w = 0; w < 3; w++) begin
            sel = w; #1;
            chk_idle("reset");
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        sel = 0; #1;
        chk_idle("idle");

        run_cfg(0, -1, "clean");

        clear_faults();
        fk[4][0] = 2'd1; fd[4][0] = 8'd1;      // ch0 returns 21 instead of 20
        run_cfg(0, -1, "data_err");

        clear_faults();
        fk[3][0] = 2'd2; fk[3][1] = 2'd2;      // response without rvalid on both channels
        run_cfg(0, -1, "resp_err");

        clear_faults();
        fk[2][1] = 2'd1; fd[2][1] = 8'd7;
        run_cfg(1, -1, "stop_err");

        clear_faults();
        run_cfg(2, 6, "wrap4ch");

        for (int i = 0; i < 8; i++) begin
            int which, r;
            which = $urandom_range(0, 2);
            clear_faults();
            for (int s = 0; s < 16; s++)
                for (int c = 0; c < 4; c++) begin
                    r = $urandom_range(0, 11);
                    if (r == 0) begin
                        fk[s][c] = 2'd1;
                        fd[s][c] = 8'($urandom_range(1, 255));
                    end else if (r == 1) begin
                        fk[s][c] = 2'd2;
                    end
                end
            run_cfg(which, $urandom_range(0, 15), "rand");
        end

        // Reset in the middle of a run with an error already counted.
        clear_faults();
        fk[2][0] = 2'd2;
        sel = 0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        chk("midrst.busy_pre", 32'(busy_m), 1);
        chk("midrst.err_pre",  32'(err_m), 1);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        chk_idle("midrst");
        reset = 1'b0;
        start = 1'b0;
        @(posedge clock); #1;
        chk_idle("midrst_hold");
        clear_faults();
        run_cfg(0, -1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
